// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogrammed control sequencer. It steps through per-opcode
//   microwords and drives a registered control bus toward the datapath.
// Latency: a microword is loaded onto `signals` at the negedge CLK that consumes it.
//   A fetch edge loads word 0 of the selected opcode.
// Backpressure: while `hold` is high, sequencing freezes and `signals` and the pulses
//   read 0. Sequencing resumes on the first edge with `hold` low.
//
// Ports:
//   CLK, RST   clock and reset. State changes on negedge CLK. RST is synchronous and active-high.
//   instr      opcode, sampled only on fetch edges
//   cond       datapath flags, used by conditional-end microwords
//   hold       stall request
//   irq        interrupt request (level)
//   irq_en     interrupt enable
//   fetch      1 = the next edge is a fetch edge
//   execute    ~fetch
//   phase      index of the next microword to load
//   signals    registered control bus
//   irq_ack    pulse: interrupt entry taken
//   done       pulse: final microword of an instruction loaded
//   illegal    pulse: fetched opcode is out of range
//
// The microprogram image is supplied through UCODE_INIT, UW bits per word.
// Word address = opcode*MAX_CYCLES + phase. Word fields, LSB first:
//   SIG[SIGNAL_COUNT], END, CEN, CPOL, CSEL[COND_WIDTH].
module micro_sequencer #(
  parameter int INSTR_COUNT  = 8,
  parameter int SIGNAL_COUNT = 32,
  parameter int MAX_CYCLES   = 8,
  parameter int COND_COUNT   = 4,
  parameter int IRQ_INSTR    = INSTR_COUNT - 1,
  parameter logic [INSTR_COUNT*MAX_CYCLES*
                   (SIGNAL_COUNT+3+((COND_COUNT > 1) ? $clog2(COND_COUNT) : 1))-1:0]
                   UCODE_INIT = '0,
  localparam int INSTR_WIDTH = $clog2(INSTR_COUNT),
  localparam int CYCLE_WIDTH = $clog2(MAX_CYCLES),
  localparam int COND_WIDTH  = (COND_COUNT > 1) ? $clog2(COND_COUNT) : 1,
  localparam int UW          = SIGNAL_COUNT + 3 + COND_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [INSTR_WIDTH-1:0]  instr,
  input  logic [COND_COUNT-1:0]   cond,
  input  logic                    hold,
  input  logic                    irq,
  input  logic                    irq_en,
  output logic                    fetch,
  output logic                    execute,
  output logic [CYCLE_WIDTH-1:0]  phase,
  output logic [SIGNAL_COUNT-1:0] signals,
  output logic                    irq_ack,
  output logic                    done,
  output logic                    illegal
);

  localparam int ROM_WORDS = INSTR_COUNT * MAX_CYCLES;
  localparam int ADDR_W    = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [CYCLE_WIDTH-1:0]   phase_q, phase_d;
  logic [INSTR_WIDTH-1:0]   cur_op_q, cur_op_d;
  logic [SIGNAL_COUNT-1:0]  signals_q, signals_d;
  logic                     irq_ack_q, irq_ack_d;
  logic                     done_q, done_d;
  logic                     illegal_q, illegal_d;

  // Constant microcode ROM, unpacked from the flat parameter image.
  logic [UW-1:0] rom [ROM_WORDS];
  for (genvar g = 0; g < ROM_WORDS; g++) begin : g_rom
    assign rom[g] = UCODE_INIT[g*UW +: UW];
  end

  logic                    take_irq;
  logic                    bad_op;
  logic [INSTR_WIDTH-1:0]  load_op;
  logic [CYCLE_WIDTH-1:0]  load_ph;
  logic [ADDR_W-1:0]       load_addr;
  logic [UW-1:0]           word;
  logic                    w_end, w_cen, w_cpol;
  logic [COND_WIDTH-1:0]   w_csel;
  logic                    cond_bit;
  logic                    last;

  // Select the word this edge would load.
  // On a fetch edge, it is word 0 of the incoming opcode (or of the IRQ routine).
  // Otherwise, it is the next word of the current opcode.
  always_comb begin
    take_irq  = irq & irq_en;
    bad_op    = !take_irq && (int'(instr) >= INSTR_COUNT);
    load_op   = (state_q == ST_FETCH) ? (take_irq ? INSTR_WIDTH'(IRQ_INSTR) : instr) : cur_op_q;
    load_ph   = (state_q == ST_FETCH) ? '0 : phase_q;
    load_addr = ADDR_W'(load_op) * ADDR_W'(MAX_CYCLES) + ADDR_W'(load_ph);
    word      = rom[load_addr];
    w_end     = word[SIGNAL_COUNT];
    w_cen     = word[SIGNAL_COUNT+1];
    w_cpol    = word[SIGNAL_COUNT+2];
    w_csel    = word[SIGNAL_COUNT+3 +: COND_WIDTH];
    // A condition select beyond the implemented flags reads as 0.
    cond_bit  = 1'b0;
    for (int i = 0; i < COND_COUNT; i++) begin
      if (w_csel == COND_WIDTH'(i)) cond_bit = cond[i];
    end
    // The last phase always terminates, so phase can never wrap.
    last = w_end | (w_cen & (cond_bit ^ w_cpol)) | (int'(load_ph) == MAX_CYCLES - 1);
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cur_op_d  = cur_op_q;
    signals_d = '0;
    irq_ack_d = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    if (!hold) begin
      if (state_q == ST_FETCH && bad_op) begin
        // An out-of-range opcode behaves as a one-cycle NOP.
        // The sequencer stays in fetch.
        illegal_d = 1'b1;
        done_d    = 1'b1;
      end else begin
        if (state_q == ST_FETCH) begin
          cur_op_d  = load_op;
          irq_ack_d = take_irq;
        end
        signals_d = word[SIGNAL_COUNT-1:0];
        if (last) begin
          state_d = ST_FETCH;
          done_d  = 1'b1;
          phase_d = '0;
        end else begin
          state_d = ST_EXEC;
          phase_d = load_ph + CYCLE_WIDTH'(1);
        end
      end
    end
  end

  // The datapath acts on posedge CLK, so the sequencer advances on negedge CLK.
  always_ff @(negedge CLK) begin
    if (RST) begin
      state_q   <= ST_FETCH;
      phase_q   <= '0;
      cur_op_q  <= '0;
      signals_q <= '0;
      irq_ack_q <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cur_op_q  <= cur_op_d;
      signals_q <= signals_d;
      irq_ack_q <= irq_ack_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign fetch   = (state_q == ST_FETCH);
  assign execute = ~fetch;
  assign phase   = phase_q;
  assign signals = signals_q;
  assign irq_ack = irq_ack_q;
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer.
// The DUT is configured with INSTR_COUNT=6, MAX_CYCLES=8 and COND_COUNT=4, so opcodes 6 and 7 are illegal.
// Inputs are driven just after posedge CLK. Outputs are compared on posedge CLK, midway between the DUT's negedge updates.
module tb_micro_sequencer;

  localparam int NI  = 6;
  localparam int SC  = 32;
  localparam int MC  = 8;
  localparam int CC  = 4;
  localparam int IRQ = NI - 1;
  localparam int UW  = SC + 3 + 2;

  typedef struct packed {
    logic [1:0]  csel;
    logic        cpol;
    logic        cen;
    logic        fin;
    logic [31:0] sig;
  } uw_t;

  // Microprogram:
  //   signals = C<op><phase:8>BEEF.
  //   op0: END at word 0.
  //   op1: END at word 2.
  //   op2: CEN on cond[0] (polarity 0) at word 1; END at word 3.
  //   op3: no end marker; it runs to the forced end.
  //   op4: CEN on cond[3] (polarity 1) at word 1; END at word 2.
  //   op5 (IRQ routine): END at word 1.
  function automatic uw_t word_of(input int op, input int ph);
    uw_t w;
    w = '0;
    w.sig = {4'hC, op[3:0], ph[7:0], 16'hBEEF};
    if (op == 0 && ph == 0) w.fin = 1'b1;
    if (op == 1 && ph == 2) w.fin = 1'b1;
    if (op == 2 && ph == 1) w.cen = 1'b1;
    if (op == 2 && ph == 3) w.fin = 1'b1;
    if (op == 4 && ph == 1) begin
      w.cen  = 1'b1;
      w.csel = 2'd3;
      w.cpol = 1'b1;
    end
    if (op == 4 && ph == 2) w.fin = 1'b1;
    if (op == 5 && ph == 1) w.fin = 1'b1;
    return w;
  endfunction

  function automatic logic [NI*MC*UW-1:0] build_image();
    logic [NI*MC*UW-1:0] img;
    img = '0;
    for (int o = 0; o < NI; o++)
      for (int p = 0; p < MC; p++)
        img[(o*MC+p)*UW +: UW] = word_of(o, p);
    return img;
  endfunction

  localparam logic [NI*MC*UW-1:0] IMAGE = build_image();

  logic        CLK;
  logic        RST;
  logic [2:0]  instr;
  logic [3:0]  cond;
  logic        hold, irq, irq_en;
  logic        fetch, execute, irq_ack, done, illegal;
  logic [2:0]  phase;
  logic [31:0] signals;

  micro_sequencer #(
    .INSTR_COUNT (NI),
    .SIGNAL_COUNT(SC),
    .MAX_CYCLES  (MC),
    .COND_COUNT  (CC),
    .IRQ_INSTR   (IRQ),
    .UCODE_INIT  (IMAGE)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .instr  (instr),
    .cond   (cond),
    .hold   (hold),
    .irq    (irq),
    .irq_en (irq_en),
    .fetch  (fetch),
    .execute(execute),
    .phase  (phase),
    .signals(signals),
    .irq_ack(irq_ack),
    .done   (done),
    .illegal(illegal)
  );

  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: it applies the sequencing rules at every negedge.
  logic        m_fetch, m_ack, m_done, m_ill;
  int          m_phase, m_op;
  logic [31:0] m_sig;

  always @(negedge CLK) begin : model
    uw_t  w;
    int   op;
    int   ph;
    logic cb;
    logic last;
    m_ack  <= 1'b0;
    m_done <= 1'b0;
    m_ill  <= 1'b0;
    if (RST) begin
      m_fetch <= 1'b1;
      m_phase <= 0;
      m_sig   <= '0;
      m_op    <= 0;
    end else if (hold) begin
      m_sig <= '0;
    end else if (m_fetch && !(irq && irq_en) && int'(instr) >= NI) begin
      m_ill  <= 1'b1;
      m_done <= 1'b1;
      m_sig  <= '0;
    end else begin
      op   = m_fetch ? ((irq && irq_en) ? IRQ : int'(instr)) : m_op;
      ph   = m_fetch ? 0 : m_phase;
      w    = word_of(op, ph);
      cb   = (int'(w.csel) < CC) ? cond[w.csel] : 1'b0;
      last = w.fin || (w.cen && (cb ^ w.cpol)) || (ph == MC - 1);
      m_ack   <= m_fetch && irq && irq_en;
      m_op    <= op;
      m_sig   <= w.sig;
      m_fetch <= last;
      m_done  <= last;
      m_phase <= last ? 0 : ph + 1;
    end
  end

  always @(posedge CLK) begin
    if (chk_en) begin
      chk("cmp_fetch",   {31'd0, fetch},   {31'd0, m_fetch});
      chk("cmp_execute", {31'd0, execute}, {31'd0, !m_fetch});
      chk("cmp_phase",   {29'd0, phase},   m_phase);
      chk("cmp_signals", signals,          m_sig);
      chk("cmp_irq_ack", {31'd0, irq_ack}, {31'd0, m_ack});
      chk("cmp_done",    {31'd0, done},    {31'd0, m_done});
      chk("cmp_illegal", {31'd0, illegal}, {31'd0, m_ill});
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Hand-computed expectations that pin the model.
  task automatic expect_out(input string tag, input logic f, input int ph,
                            input logic [31:0] s, input logic d);
    chk({tag, "_fetch"},   {31'd0, fetch},   {31'd0, f});
    chk({tag, "_phase"},   {29'd0, phase},   ph);
    chk({tag, "_signals"}, signals,          s);
    chk({tag, "_done"},    {31'd0, done},    {31'd0, d});
  endtask

  initial begin
    RST = 1'b1; hold = 1'b0; irq = 1'b0; irq_en = 1'b0; instr = 3'd0; cond = 4'd0;
    cyc();
    chk_en = 1'b1;
    cyc();
    expect_out("rst", 1'b1, 0, 32'h0, 1'b0);
    chk("rst_ack", {31'd0, irq_ack}, 32'd0);
    chk("rst_ill", {31'd0, illegal}, 32'd0);

    // opcode 1; instr changes mid-instruction and must be ignored
    RST = 1'b0; instr = 3'd1;
    cyc(); expect_out("op1_w0", 1'b0, 1, 32'hC100BEEF, 1'b0);
    instr = 3'd4;
    cyc(); expect_out("op1_w1", 1'b0, 2, 32'hC101BEEF, 1'b0);
    cyc(); expect_out("op1_w2", 1'b1, 0, 32'hC102BEEF, 1'b1);

    // single-word opcode back to back
    instr = 3'd0;
    repeat (3) begin
      cyc(); expect_out("op0_b2b", 1'b1, 0, 32'hC000BEEF, 1'b1);
    end

    // conditional end taken, then not taken
    instr = 3'd2; cond = 4'b0001;
    cyc(); expect_out("op2_w0", 1'b0, 1, 32'hC200BEEF, 1'b0);
    cyc(); expect_out("op2_cen_hit", 1'b1, 0, 32'hC201BEEF, 1'b1);
    cond = 4'b0000;
    cyc(); cyc(); expect_out("op2_cen_miss", 1'b0, 2, 32'hC201BEEF, 1'b0);
    cyc(); expect_out("op2_w2", 1'b0, 3, 32'hC202BEEF, 1'b0);
    cyc(); expect_out("op2_w3", 1'b1, 0, 32'hC203BEEF, 1'b1);

    // inverted polarity on cond[3]
    instr = 3'd4; cond = 4'b1000;
    cyc(); cyc(); expect_out("op4_pol_miss", 1'b0, 2, 32'hC401BEEF, 1'b0);
    cyc(); expect_out("op4_w2", 1'b1, 0, 32'hC402BEEF, 1'b1);
    cond = 4'b0000;
    cyc(); cyc(); expect_out("op4_pol_hit", 1'b1, 0, 32'hC401BEEF, 1'b1);

    // hold after word 1
    instr = 3'd1;
    cyc(); cyc(); expect_out("hold_pre", 1'b0, 2, 32'hC101BEEF, 1'b0);
    hold = 1'b1;
    repeat (3) begin
      cyc(); expect_out("hold", 1'b0, 2, 32'h0, 1'b0);
    end
    hold = 1'b0;
    cyc(); expect_out("hold_release", 1'b1, 0, 32'hC102BEEF, 1'b1);

    // interrupt raised mid-opcode 2 is taken at the next fetch
    instr = 3'd2; cond = 4'b0000;
    cyc(); expect_out("irq_op2_w0", 1'b0, 1, 32'hC200BEEF, 1'b0);
    irq = 1'b1; irq_en = 1'b1;
    cyc(); expect_out("irq_mid", 1'b0, 2, 32'hC201BEEF, 1'b0);
    chk("irq_mid_ack", {31'd0, irq_ack}, 32'd0);
    cyc(); cyc(); expect_out("irq_op2_done", 1'b1, 0, 32'hC203BEEF, 1'b1);
    instr = 3'd1;
    cyc(); expect_out("irq_entry", 1'b0, 1, 32'hC500BEEF, 1'b0);
    chk("irq_ack_hi", {31'd0, irq_ack}, 32'd1);
    irq_en = 1'b0;
    cyc(); expect_out("irq_w1", 1'b1, 0, 32'hC501BEEF, 1'b1);
    chk("irq_ack_pulse", {31'd0, irq_ack}, 32'd0);
    instr = 3'd0;
    cyc(); expect_out("irq_masked", 1'b1, 0, 32'hC000BEEF, 1'b1);
    chk("irq_masked_ack", {31'd0, irq_ack}, 32'd0);
    irq = 1'b0;

    // illegal opcodes
    instr = 3'd7;
    cyc(); expect_out("ill7", 1'b1, 0, 32'h0, 1'b1);
    chk("ill7_flag", {31'd0, illegal}, 32'd1);
    instr = 3'd6;
    cyc(); expect_out("ill6", 1'b1, 0, 32'h0, 1'b1);
    chk("ill6_flag", {31'd0, illegal}, 32'd1);
    instr = 3'd0;
    cyc(); expect_out("ill_after", 1'b1, 0, 32'hC000BEEF, 1'b1);
    chk("ill_clear", {31'd0, illegal}, 32'd0);

    // reset mid-instruction (hold is also high; reset wins), then a forced end
    instr = 3'd3;
    cyc(); cyc(); cyc(); expect_out("op3_w2", 1'b0, 3, 32'hC302BEEF, 1'b0);
    RST = 1'b1; hold = 1'b1;
    cyc(); expect_out("midop_rst", 1'b1, 0, 32'h0, 1'b0);
    RST = 1'b0; hold = 1'b0;
    repeat (7) cyc();
    expect_out("op3_w6", 1'b0, 7, 32'hC306BEEF, 1'b0);
    cyc(); expect_out("op3_forced", 1'b1, 0, 32'hC307BEEF, 1'b1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
